// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types for the memory-stage bus sequencer:
//   msize_t      - access size (1/2/4/8 bytes), encoded as log2(bytes)
//   mau_state_t  - sequencer state
//   is_misaligned() - true when the low address bits do not fit the size
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mau_state_t;

   function automatic logic is_misaligned(input logic [2:0] addr_lo, input msize_t size);
      logic bad;
      bad = 1'b0;
      case (size)
         MSIZE1:  bad = 1'b0;
         MSIZE2:  bad = addr_lo[0];
         MSIZE4:  bad = |addr_lo[1:0];
         MSIZE8:  bad = |addr_lo[2:0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Data-bus request/response bundle.
//   dreq_valid/addr/size/strobe/data : request, driven by the sequencer (master)
//   dresp_data_ok/dresp_data          : response, driven by the memory (slave)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic        dreq_valid;
   logic [63:0] dreq_addr;
   msize_t      dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_data_ok, dresp_data
   );

endinterface

// File: rtl/mem_access_unit_load_extract.sv
// ---------------------------------------------------------------------------
// mem_access_unit_load_extract
// Combinational load-data extraction: shifts the addressed bytes of the full
// 64-bit read word down to bit 0, keeps 1/2/4/8 bytes and sign- or
// zero-extends.
//   i_data     in  64  full read word from the bus
//   i_off      in  3   byte offset within the word (addr[2:0])
//   i_size     in  msize_t access size
//   i_unsigned in  1   zero-extend instead of sign-extend
//   o_rdata    out 64  extended result
// ---------------------------------------------------------------------------
module mem_access_unit_load_extract
   import mem_access_unit_pkg::*;
(
   input  logic [63:0] i_data,
   input  logic [2:0]  i_off,
   input  msize_t      i_size,
   input  logic        i_unsigned,
   output logic [63:0] o_rdata
);

   logic [63:0] w_word;

   assign w_word = i_data >> {i_off, 3'b000};

   always_comb begin
      o_rdata = w_word;
      case (i_size)
         MSIZE1:  o_rdata = i_unsigned ? {56'd0, w_word[7:0]}
                                       : {{56{w_word[7]}}, w_word[7:0]};
         MSIZE2:  o_rdata = i_unsigned ? {48'd0, w_word[15:0]}
                                       : {{48{w_word[15]}}, w_word[15:0]};
         MSIZE4:  o_rdata = i_unsigned ? {32'd0, w_word[31:0]}
                                       : {{32{w_word[31]}}, w_word[31:0]};
         MSIZE8:  o_rdata = w_word;
         default: o_rdata = w_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-stage bus sequencer. Accepts a load/store from the memory stage,
// drives a held-stable data-bus request until the response arrives, extracts
// load data and reports completion for one cycle; stalls the pipeline while
// the access is in flight.
//   clk, reset         clock / asynchronous active-high reset
//   in_valid .. in_strobe  memory-stage instruction and aligned store data
//   flush              squash the current memory-stage instruction
//   dbus               data-bus request/response (master side)
//   done, stall        completion / pipeline stall
//   rdata, misalign    extended load result / misaligned-access indication
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_is_load,
   input  logic                  in_is_store,
   input  logic                  in_unsigned,
   input  logic [63:0]           in_addr,
   input  msize_t                in_msize,
   input  logic [63:0]           in_wd,
   input  logic [7:0]            in_strobe,
   input  logic                  flush,
   mem_access_unit_if.master     dbus,
   output logic                  done,
   output logic                  stall,
   output logic [63:0]           rdata,
   output logic                  misalign
);

   mau_state_t  r_state;
   logic        r_dreq_valid;
   logic [63:0] r_addr;
   msize_t      r_size;
   logic [7:0]  r_strobe;
   logic [63:0] r_data;
   logic        r_unsigned;
   logic        r_squash;
   logic        r_misalign;
   logic [63:0] r_rdata;

   logic        w_mem_op;
   logic        w_accept;
   logic        w_misaligned;
   logic [63:0] w_rdata;

   assign w_mem_op     = in_is_load | in_is_store;
   assign w_accept     = (r_state == IDLE) & in_valid & w_mem_op & ~flush;
   assign w_misaligned = is_misaligned(in_addr[2:0], in_msize);

   mem_access_unit_load_extract u_extract (
      .i_data     (dbus.dresp_data),
      .i_off      (r_addr[2:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_rdata    (w_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_dreq_valid <= 1'b0;
         r_addr       <= '0;
         r_size       <= MSIZE1;
         r_strobe     <= '0;
         r_data       <= '0;
         r_unsigned   <= 1'b0;
         r_squash     <= 1'b0;
         r_misalign   <= 1'b0;
         r_rdata      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_misalign <= 1'b0;
               if (w_accept) begin
                  if (w_misaligned) begin
                     // No bus access at all; finish with misalign next cycle.
                     r_state    <= DONE;
                     r_misalign <= 1'b1;
                  end else begin
                     r_state      <= REQ;
                     r_dreq_valid <= 1'b1;
                     r_addr       <= in_addr;
                     r_size       <= in_msize;
                     // Loads never write, regardless of what the aligner presents.
                     r_strobe     <= in_is_store ? in_strobe : 8'h00;
                     r_data       <= in_wd;
                     r_unsigned   <= in_unsigned;
                  end
               end
            end
            REQ: begin
               // The bus cannot be abandoned; remember the flush and keep
               // the request up until the response arrives.
               if (flush) begin
                  r_squash <= 1'b1;
               end
               if (dbus.dresp_data_ok) begin
                  r_dreq_valid <= 1'b0;
                  r_squash     <= 1'b0;
                  if (r_squash | flush) begin
                     r_state <= IDLE;
                  end else begin
                     r_state <= DONE;
                     r_rdata <= w_rdata;
                  end
               end
            end
            DONE: begin
               r_state    <= IDLE;
               r_misalign <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_dreq_valid <= 1'b0;
               r_squash     <= 1'b0;
               r_misalign   <= 1'b0;
            end
         endcase
      end
   end

   assign dbus.dreq_valid  = r_dreq_valid;
   assign dbus.dreq_addr   = r_addr;
   assign dbus.dreq_size   = r_size;
   assign dbus.dreq_strobe = r_strobe;
   assign dbus.dreq_data   = r_data;

   // Non-memory instructions complete combinationally while idle.
   assign done     = ~flush & ((r_state == DONE) |
                               ((r_state == IDLE) & in_valid & ~w_mem_op));
   assign stall    = in_valid & ~done & ~flush;
   assign rdata    = r_rdata;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_is_load, in_is_store, in_unsigned, flush;
   logic [63:0] in_addr, in_wd;
   msize_t      in_msize;
   logic [7:0]  in_strobe;
   logic        done, stall, misalign;
   logic [63:0] rdata;

   mem_access_unit_if dbus ();

   mem_access_unit dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_is_load  (in_is_load),
      .in_is_store (in_is_store),
      .in_unsigned (in_unsigned),
      .in_addr     (in_addr),
      .in_msize    (in_msize),
      .in_wd       (in_wd),
      .in_strobe   (in_strobe),
      .flush       (flush),
      .dbus        (dbus),
      .done        (done),
      .stall       (stall),
      .rdata       (rdata),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Expected outputs for the current cycle, set by the stimulus process.
   bit          check_en = 1'b0;
   bit          exp_dreq_valid, exp_done, exp_misalign, exp_load_done, exp_store;
   logic [63:0] exp_addr, exp_data, exp_rdata;
   msize_t      exp_size;
   logic [7:0]  exp_strobe;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference extraction by plain arithmetic on byte counts.
   function automatic logic [63:0] ref_extract(input logic [63:0] d, input logic [63:0] a,
                                               input msize_t sz, input bit uns);
      int          nbytes;
      int          off;
      logic [63:0] v;
      logic [63:0] lim;
      nbytes = 1 << int'(sz);
      off    = int'(a % 64'd8);
      v      = d >> (off * 8);
      if (nbytes == 8) return v;
      lim = 64'd1 << (nbytes * 8);
      v   = v % lim;
      if (!uns && v >= (lim >> 1)) v = v - lim;
      return v;
   endfunction

   always @(negedge clk) begin
      if (check_en) begin
         chk("dreq_valid", {63'd0, dbus.dreq_valid}, {63'd0, exp_dreq_valid});
         chk("done", {63'd0, done}, {63'd0, exp_done});
         chk("stall", {63'd0, stall}, {63'd0, in_valid & ~exp_done & ~flush});
         if (exp_dreq_valid) begin
            chk("dreq_addr", dbus.dreq_addr, exp_addr);
            chk("dreq_size", {62'd0, dbus.dreq_size}, {62'd0, exp_size});
            chk("dreq_strobe", {56'd0, dbus.dreq_strobe}, {56'd0, exp_strobe});
            if (exp_store) chk("dreq_data", dbus.dreq_data, exp_data);
         end
         if (exp_done) begin
            chk("misalign", {63'd0, misalign}, {63'd0, exp_misalign});
            if (exp_load_done) chk("rdata", rdata, exp_rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      in_valid = 0; in_is_load = 0; in_is_store = 0; in_unsigned = 0; flush = 0;
      dbus.dresp_data_ok = 0;
      exp_dreq_valid = 0; exp_done = 0; exp_misalign = 0; exp_load_done = 0; exp_store = 0;
   endtask

   // One load/store. lat = cycle (counted from accept=0) in which data_ok is given.
   // flush_at: -1 none, 0 at accept, 1..lat during REQ, lat+1 in the done cycle.
   task automatic mem_op(input string tag, input bit ld, input bit st, input bit uns,
                         input logic [63:0] addr, input msize_t sz, input logic [63:0] wd,
                         input logic [7:0] strb, input logic [63:0] resp,
                         input int lat, input int flush_at);
      bit mis;
      bit squashed;
      mis = (addr % (64'd1 << int'(sz))) != 0;
      $display("txn %s: ld=%0d st=%0d addr=0x%h size=%0d lat=%0d flush_at=%0d",
               tag, ld, st, addr, 1 << int'(sz), lat, flush_at);
      step();
      idle_all();
      in_valid = 1; in_is_load = ld; in_is_store = st; in_unsigned = uns;
      in_addr = addr; in_msize = sz; in_wd = wd; in_strobe = strb;
      flush = (flush_at == 0);
      if (flush_at == 0) begin
         step(); idle_all();
         step();
         return;
      end
      if (mis) begin
         step();
         exp_done = 1; exp_misalign = 1;
         step(); idle_all();
         return;
      end
      exp_addr = addr; exp_size = sz; exp_strobe = st ? strb : 8'h00;
      exp_data = wd; exp_store = st;
      for (int c = 1; c <= lat; c++) begin
         step();
         exp_dreq_valid = 1;
         flush = (c == flush_at);
         if (flush_at >= 1 && c > flush_at) in_valid = 0;
         dbus.dresp_data_ok = (c == lat);
         dbus.dresp_data = (c == lat) ? resp : ~resp;
      end
      step();
      squashed = (flush_at >= 1) && (flush_at <= lat);
      dbus.dresp_data_ok = 0;
      exp_dreq_valid = 0;
      if (squashed) in_valid = 0;
      flush = (flush_at == lat + 1);
      exp_done = !squashed && !flush;
      exp_misalign = 0;
      exp_load_done = ld;
      exp_rdata = ref_extract(resp, addr, sz, uns);
      step(); idle_all();
   endtask

   initial begin
      reset = 1;
      idle_all();
      in_addr = 0; in_msize = MSIZE1; in_wd = 0; in_strobe = 0;
      dbus.dresp_data = 0;
      exp_addr = 0; exp_size = MSIZE1; exp_strobe = 0; exp_data = 0; exp_rdata = 0;
      step(); step();
      chk("rst_dreq_valid", {63'd0, dbus.dreq_valid}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_misalign", {63'd0, misalign}, 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_dreq_addr", dbus.dreq_addr, 64'd0);
      reset = 0;
      check_en = 1;

      // lw, data_ok three cycles after the request starts
      mem_op("lw", 1, 0, 0, 64'h0000_0000_0000_1004, MSIZE4, 64'hDEAD, 8'hFF,
             64'h8000_0001_0000_0000, 4, -1);
      chk("lw_rdata_literal", rdata, 64'hFFFF_FFFF_8000_0001);
      // sb to byte 3
      mem_op("sb", 0, 1, 0, 64'h0000_0000_0000_0003, MSIZE1, 64'h0000_0000_AB00_0000, 8'h08,
             64'h1111_2222_3333_4444, 2, -1);
      // misaligned lh
      mem_op("lh_mis", 1, 0, 0, 64'h0000_0000_0000_0003, MSIZE2, 64'h0, 8'h00, 64'h0, 1, -1);
      // lb / lbu from byte 5
      mem_op("lb", 1, 0, 0, 64'h0000_0000_0000_0005, MSIZE1, 64'h0, 8'h00,
             64'h0000_9A00_0000_0000, 1, -1);
      chk("lb_rdata_literal", rdata, 64'hFFFF_FFFF_FFFF_FF9A);
      mem_op("lbu", 1, 0, 1, 64'h0000_0000_0000_0005, MSIZE1, 64'h0, 8'h00,
             64'h0000_9A00_0000_0000, 2, -1);
      chk("lbu_rdata_literal", rdata, 64'h0000_0000_0000_009A);
      // flush one cycle into REQ, flush with data_ok, flush in done, flush at accept
      mem_op("sw_flush_req", 0, 1, 0, 64'h0000_0000_0000_0020, MSIZE4, 64'h0000_0000_CAFE_F00D,
             8'h0F, 64'h0, 4, 2);
      mem_op("lw_flush_ok", 1, 0, 0, 64'h0000_0000_0000_0040, MSIZE4, 64'h0, 8'h00,
             64'h0000_0000_7777_7777, 2, 2);
      mem_op("lw_flush_done", 1, 0, 0, 64'h0000_0000_0000_0044, MSIZE4, 64'h0, 8'h00,
             64'h5555_5555_0000_0000, 1, 2);
      mem_op("lw_flush_idle", 1, 0, 0, 64'h0000_0000_0000_0048, MSIZE4, 64'h0, 8'h00,
             64'h0, 1, 0);
      // lhu from the top halfword
      mem_op("lhu", 1, 0, 1, 64'h0000_0000_0000_0006, MSIZE2, 64'h0, 8'h00,
             64'h8001_0000_0000_0000, 3, -1);
      chk("lhu_rdata_literal", rdata, 64'h0000_0000_0000_8001);

      // non-memory instruction
      $display("txn nonmem: in_valid with no load/store");
      step(); idle_all();
      in_valid = 1; exp_done = 1;
      step(); idle_all();

      // reset pulsed while a request is outstanding
      $display("txn reset_mid_req: ld addr=0x100 interrupted by reset");
      step(); idle_all();
      in_valid = 1; in_is_load = 1; in_addr = 64'h100; in_msize = MSIZE8;
      step();
      exp_dreq_valid = 1; exp_addr = 64'h100; exp_size = MSIZE8; exp_strobe = 8'h00;
      @(negedge clk); #1;
      check_en = 0;
      reset = 1;
      #1;
      chk("rstmid_dreq_valid", {63'd0, dbus.dreq_valid}, 64'd0);
      chk("rstmid_dreq_addr", dbus.dreq_addr, 64'd0);
      chk("rstmid_rdata", rdata, 64'd0);
      chk("rstmid_done", {63'd0, done}, 64'd0);
      idle_all();
      step();
      reset = 0;
      check_en = 1;
      step();
      mem_op("ld_after_rst", 1, 0, 0, 64'h0000_0000_0000_0008, MSIZE8, 64'h0, 8'h00,
             64'h0123_4567_89AB_CDEF, 1, -1);
      chk("ld_rdata_literal", rdata, 64'h0123_4567_89AB_CDEF);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
